// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/DM memory port arbiter.
// The state encoding is fixed so that IDLE decodes as all zeros.
package mem_arb_pkg;

  localparam int ADDR_W_DEF       = 64;
  localparam int DATA_W_DEF       = 64;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int TIMEOUT_DEF      = 16;

  localparam logic [2:0] FUNCT3_WORD = 3'b010;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUSY_IF = 3'd1,
    BUSY_DM = 3'd2,
    RESP_IF = 3'd3,
    RESP_DM = 3'd4
  } arb_state_e;

endpackage

// File: rtl/arb_timeout_timer.sv
// Backend watchdog. Loaded on clr and counted down while en is high, so
// expire asserts once TIMEOUT-1 enabled cycles have elapsed since the clear.
module arb_timeout_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [7:0] LOAD_VAL = 8'(TIMEOUT - 1);

  logic [7:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= LOAD_VAL;
    end else if (en && (count_q != 8'd0)) begin
      count_q <= count_q - 8'd1;
    end
  end

  assign expire = (count_q == 8'd0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported backend memory between instruction fetch and
// data memory. DM has priority; a grant streak counter lets IF through.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transaction; grant decision taken here
// BUSY_IF | IF access issued on the backend, waiting for mem_ack/timeout
// BUSY_DM | DM access issued on the backend, waiting for mem_ack/timeout
// RESP_IF | if_ready pulse (bus_err if the access timed out)
// RESP_DM | dm_ready pulse (bus_err if the access timed out)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [2:0]        dm_funct3,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err
);

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  logic [3:0]        streak_q;
  logic [3:0]        streak_inc;
  logic              busy;
  logic              timer_exp;
  logic              err_q;
  logic              if_ready_q, dm_ready_q;
  logic [31:0]       if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [2:0]        mem_funct3_q;

  assign busy       = (state_q == BUSY_IF) || (state_q == BUSY_DM);
  assign streak_inc = (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;

  arb_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (state_q == IDLE),
    .en     (busy),
    .expire (timer_exp)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (dm_req && if_req)
          state_d = (streak_q == STREAK_MAX) ? BUSY_IF : BUSY_DM;
        else if (dm_req)
          state_d = BUSY_DM;
        else if (if_req)
          state_d = BUSY_IF;
      end
      // an ack arriving on the expiry cycle still completes normally
      BUSY_IF: if (mem_ack || timer_exp) state_d = RESP_IF;
      BUSY_DM: if (mem_ack || timer_exp) state_d = RESP_DM;
      RESP_IF: state_d = IDLE;
      RESP_DM: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_ready_q   <= 1'b0;
      dm_ready_q   <= 1'b0;
      err_q        <= 1'b0;
      streak_q     <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_funct3_q <= '0;
    end else begin
      if_ready_q <= (state_d == RESP_IF);
      dm_ready_q <= (state_d == RESP_DM);
      err_q      <= busy && timer_exp && !mem_ack;

      if (state_q == IDLE) begin
        if (state_d == BUSY_DM) begin
          mem_req_q    <= 1'b1;
          mem_we_q     <= dm_we;
          mem_addr_q   <= dm_addr;
          mem_wdata_q  <= dm_wdata;
          mem_funct3_q <= dm_funct3;
          streak_q     <= if_req ? streak_inc : 4'd0;
        end else if (state_d == BUSY_IF) begin
          mem_req_q    <= 1'b1;
          mem_we_q     <= 1'b0;
          mem_addr_q   <= if_addr;
          mem_wdata_q  <= '0;
          mem_funct3_q <= FUNCT3_WORD;
          streak_q     <= 4'd0;
        end
      end

      if (busy && (mem_ack || timer_exp)) begin
        mem_req_q <= 1'b0;
        if (state_q == BUSY_IF)
          if_rdata_q <= mem_ack ? mem_rdata[31:0] : 32'd0;
        else
          dm_rdata_q <= mem_ack ? mem_rdata : '0;
      end
    end
  end

  assign if_ready   = if_ready_q;
  assign dm_ready   = dm_ready_q;
  assign bus_err    = err_q;
  assign if_rdata   = if_rdata_q;
  assign dm_rdata   = dm_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_funct3 = mem_funct3_q;
  assign if_stall   = if_req & ~if_ready_q;
  assign dm_stall   = dm_req & ~dm_ready_q;

endmodule
